// File: rtl/fpu_pack_arbiter_if.sv
// fpu_pack_arbiter_if: unpacked FPU results in, packed writeback result out
interface fpu_pack_arbiter_if #(
  parameter int EXPONENT_WIDTH = 11,
  parameter int SIGNIFICAND_WIDTH = 52
);
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic req0_sign;
  logic [EXPONENT_WIDTH-1:0] req0_exponent;
  logic [SIGNIFICAND_WIDTH:0] req0_significand;
  logic req1_sign;
  logic [EXPONENT_WIDTH-1:0] req1_exponent;
  logic [SIGNIFICAND_WIDTH:0] req1_significand;
  logic out_valid;
  logic out_ready;
  logic [EXPONENT_WIDTH+SIGNIFICAND_WIDTH:0] out_fp;
  logic out_src;
  modport master (
    output req_valid, req0_sign, req0_exponent, req0_significand,
           req1_sign, req1_exponent, req1_significand, out_ready,
    input  req_ready, out_valid, out_fp, out_src
  );
  modport slave (
    input  req_valid, req0_sign, req0_exponent, req0_significand,
           req1_sign, req1_exponent, req1_significand, out_ready,
    output req_ready, out_valid, out_fp, out_src
  );
endinterface

// File: rtl/fpu_pack_arbiter.sv
// fpu_pack_arbiter: round-robin share of one IEEE packing/writeback slot between adder and multiplier
module fpu_pack_arbiter #(
  parameter int EXPONENT_WIDTH = 11,
  parameter int SIGNIFICAND_WIDTH = 52
) (
  input logic clk,
  input logic rst_n,
  fpu_pack_arbiter_if.slave bus
);
  localparam int PACKED_WIDTH = 1 + EXPONENT_WIDTH + SIGNIFICAND_WIDTH;
  logic last_grant;
  logic load_en;
  logic grant;
  logic xfer;
  logic [PACKED_WIDTH-1:0] packed0;
  logic [PACKED_WIDTH-1:0] packed1;
  // rst_n gates load_en so no requester is accepted while held in reset
  always_comb begin
    load_en = rst_n && (!bus.out_valid || bus.out_ready);
    grant = (&bus.req_valid) ? !last_grant : bus.req_valid[1];
    xfer = load_en && |bus.req_valid;
    bus.req_ready = xfer ? (grant ? 2'b10 : 2'b01) : 2'b00;
    packed0 = {bus.req0_sign, bus.req0_exponent, bus.req0_significand[SIGNIFICAND_WIDTH-1:0]};
    packed1 = {bus.req1_sign, bus.req1_exponent, bus.req1_significand[SIGNIFICAND_WIDTH-1:0]};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_fp <= '0;
      bus.out_src <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_fp <= grant ? packed1 : packed0;
      bus.out_src <= grant;
      last_grant <= grant;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/fpu_pack_arbiter.md
Name: fpu_pack_arbiter

Overview:
- Shares one packing/writeback stage between two FPU execution units: requester 0 is the adder and requester 1 is the multiplier.
- Each unit presents an unpacked result (sign, biased exponent, significand with implied bit) on a valid/ready handshake.
- The block grants one requester per cycle using round-robin priority and packs the winner into IEEE layout.
- The packed word is held in a single registered output slot with valid/ready flow control toward the register-file writeback.

Parameters:
- EXPONENT_WIDTH, 11, biased exponent width.
- SIGNIFICAND_WIDTH, 52, stored fraction width; the unpacked significand carries one extra implied bit.
- PACKED_WIDTH (localparam), 1+EXPONENT_WIDTH+SIGNIFICAND_WIDTH = 64, packed word width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  bit i: requester i presents a result.
- req_ready  output  2  bit i: requester i's result is accepted this cycle.
- req0_sign  input  1  adder result sign.
- req0_exponent  input  EXPONENT_WIDTH  adder result biased exponent.
- req0_significand  input  SIGNIFICAND_WIDTH+1  adder significand, implied bit at MSB.
- req1_sign  input  1  multiplier result sign.
- req1_exponent  input  EXPONENT_WIDTH  multiplier result biased exponent.
- req1_significand  input  SIGNIFICAND_WIDTH+1  multiplier significand, implied bit at MSB.
- out_valid  output  1  out_fp/out_src hold a valid packed result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_fp  output  PACKED_WIDTH  packed {sign, exponent, significand[SIGNIFICAND_WIDTH-1:0]}.
- out_src  output  1  index of the requester that produced out_fp.

Behaviour:
- Reset (async assert, rst_n low):
  - out_valid=0, out_fp=0, out_src=0.
  - last_grant=1, so requester 0 wins first.
  - req_ready=0 while in reset.
  - Any in-flight result is discarded; requesters must re-present after reset.
- Slot load enable: load_en = !out_valid || out_ready, evaluated combinationally each cycle.
- Arbitration (combinational):
  - Exactly one valid requester: that requester is granted.
  - Both valid: grant goes to the requester != last_grant.
  - Neither valid: no grant.
- Handshake:
  - req_ready[i] = load_en && grant==i.
  - At most one req_ready bit is high per cycle.
  - req_ready does not depend on req_valid of the same requester beyond arbitration, and is never high for a non-valid requester.
  - A transfer occurs on req_valid[i] && req_ready[i].
- On transfer, at the rising edge:
  - out_fp <= {reqi_sign, reqi_exponent, reqi_significand[SIGNIFICAND_WIDTH-1:0]}; the implied bit (MSB) is dropped, not checked.
  - out_src <= i, out_valid <= 1, last_grant <= i.
- last_grant changes only on a transfer. Cycles with no grant or with backpressure leave it unchanged.
- Output side:
  - out_valid && out_ready with no new transfer: out_valid <= 0. out_fp/out_src keep their last value.
  - out_valid && !out_ready: out_fp, out_src and out_valid hold stable, and req_ready=0.
- Latency and throughput:
  - A result is visible on out_fp exactly 1 cycle after its transfer.
  - With out_ready held 1, one result per cycle is sustained.
- Fairness: with both requesters continuously valid and out_ready=1, grants strictly alternate 0,1,0,1...; neither requester waits more than 1 transfer.
- Requester obligation: once req_valid[i] is asserted, payload and valid hold until accepted. The block does not enforce this.
- No combinational path from out_ready to out_fp. A path out_ready -> req_ready is permitted.

Test Plan:
- Single packing:
  - Stimulus: after reset, req_valid=01, req0 = {0, 11'h3FF, 53'h10000000000000}, out_ready=1.
  - Required: req_ready=01 that cycle; next cycle out_valid=1, out_fp=64'h3FF0000000000000, out_src=0.
- Implied-bit drop and sign:
  - Stimulus: req1 = {1, 11'h400, 53'h18000000000000}.
  - Required: out_fp=64'hC008000000000000 (-3.0), out_src=1.
- Round-robin:
  - Stimulus: both valid for 6 cycles, out_ready=1.
  - Required: accepted sources 0,1,0,1,0,1; req_ready never 11.
- Backpressure:
  - Stimulus: out_valid=1, out_ready=0 for 3 cycles with both requesters valid.
  - Required: req_ready=00, out_fp/out_src stable, last_grant unchanged.
  - Then out_ready=1: the new transfer loads in the same cycle the old result is consumed (no bubble).
- Drain:
  - Stimulus: out_valid=1, out_ready=1, no requests.
  - Required: next cycle out_valid=0 and out_fp keeps its last value.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 asynchronously between clock edges while out_valid=1.
  - Required: out_valid, out_fp and out_src go to 0 immediately.
  - After release with both requesters valid, requester 0 is granted first.
